// File: rtl/servo_pwm.sv
// RC-servo PWM generator, one channel per instance.
// Each frame is PERIOD_CYC cycles long and begins with a single high pulse of
// MIN_CYC + active_pos * STEP_CYC cycles. The position is sampled only on the
// edge that starts a frame, so a bus write never produces a runt pulse.
// Optional feature: define SERVO_PWM_SLEW_EN to limit the per-frame change of
// active_pos to SLEW_MAX; otherwise position is loaded directly.
module servo_pwm #(
    parameter int unsigned PERIOD_CYC = 1000000,
    parameter int unsigned MIN_CYC    = 50000,
    parameter int unsigned STEP_CYC   = 794,
    parameter int unsigned SLEW_MAX   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [5:0] position,
    output logic       pwm_out,
    output logic       frame_start,
    output logic [5:0] active_pos,
    output logic       busy
);

    localparam int unsigned CW = $clog2(PERIOD_CYC);

    localparam logic [CW-1:0] MinCyc     = CW'(MIN_CYC);
    localparam logic [CW-1:0] StepCyc    = CW'(STEP_CYC);
    localparam logic [CW-1:0] PeriodLast = CW'(PERIOD_CYC - 1);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    pos_q, pos_d;
    logic          pwm_q, pwm_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic [5:0]    load_pos;
    logic [CW-1:0] pulse_last;

    // Last counter value of the high phase; cannot overflow under a legal configuration.
    assign pulse_last = MinCyc + CW'(pos_q) * StepCyc - CW'(1);

`ifdef SERVO_PWM_SLEW_EN
    localparam logic [5:0] SlewLim = (SLEW_MAX > 63) ? 6'd63 : 6'(SLEW_MAX);

    logic [5:0] diff;

    // Step active_pos toward the target by at most SlewLim per frame.
    always_comb begin
        diff     = '0;
        load_pos = pos_q;
        if (position >= pos_q) begin
            diff     = position - pos_q;
            load_pos = (diff > SlewLim) ? pos_q + SlewLim : position;
        end else begin
            diff     = pos_q - position;
            load_pos = (diff > SlewLim) ? pos_q - SlewLim : position;
        end
    end
`else
    assign load_pos = position;
`endif

    // Next-state logic: frame sequencing and the registered output values.
    always_comb begin
        logic start;
        start   = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (enable) start = 1'b1;
            end
            StHigh: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == pulse_last) state_d = StLow;
            end
            StLow: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == PeriodLast) begin
                    if (enable) begin
                        start = 1'b1;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (start) begin
            state_d = StHigh;
            cnt_d   = '0;
            pos_d   = load_pos;
        end

        // Outputs follow the next state so they change on the same edge as the FSM.
        pwm_d   = (state_d == StHigh);
        start_d = start;
        busy_d  = (state_d != StIdle);
    end

    // State and output registers; reset acts immediately, even mid-pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pos_q   <= '0;
            pwm_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            pwm_q   <= pwm_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign frame_start = start_q;
    assign active_pos  = pos_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_servo_pwm.sv
// Self-checking bench for servo_pwm with a frame-level reference model.
// Build with or without SERVO_PWM_SLEW_EN; the model follows the same macro.
module tb_servo_pwm;

    localparam int PERIOD = 100;
    localparam int MINC   = 10;
    localparam int STEP   = 1;
    localparam int SLEW   = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [5:0] position;
    logic       pwm_out;
    logic       frame_start;
    logic [5:0] active_pos;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int model_pos = 0;

    servo_pwm #(
        .PERIOD_CYC(PERIOD),
        .MIN_CYC   (MINC),
        .STEP_CYC  (STEP),
        .SLEW_MAX  (SLEW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .position   (position),
        .pwm_out    (pwm_out),
        .frame_start(frame_start),
        .active_pos (active_pos),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        if (!(MINC >= 1 && MINC + 63 * STEP < PERIOD))
            $fatal(1, "FAIL config: illegal PERIOD/MIN/STEP combination");
    end

    // Reference: position used by the next frame given the current one and the target.
    function automatic int next_pos(int cur, int tgt);
`ifdef SERVO_PWM_SLEW_EN
        if (tgt > cur) return (tgt - cur > SLEW) ? cur + SLEW : tgt;
        return (cur - tgt > SLEW) ? cur - SLEW : tgt;
`else
        return tgt;
`endif
    endfunction

    function automatic int width_of(int p);
        return MINC + p * STEP;
    endfunction

    // Walk one frame from its frame_start negedge to the next frame_start (or idle).
    // Optional stimulus events fire at a given cycle index within the frame.
    task automatic measure_frame(input int change_at, input logic [5:0] new_pos,
                                 input int drop_at, input int reen_at,
                                 output int high, output int len,
                                 output bit pos_stable, output bit ended);
        logic [5:0] ap0;
        ap0 = active_pos;
        high = 0;
        len = 0;
        pos_stable = 1'b1;
        ended = 1'b0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            if (i > 0 && (frame_start || !busy)) begin
                ended = 1'b1;
                break;
            end
            if (pwm_out) high++;
            if (active_pos !== ap0) pos_stable = 1'b0;
            len++;
            if (i == change_at) position = new_pos;
            if (i == drop_at) enable = 1'b0;
            if (i == reen_at) enable = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        position = 6'd0;
        repeat (2) @(negedge clk);
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm got %b want 0", pwm_out); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", frame_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (active_pos !== 6'd0) begin errors++; $display("FAIL reset_pos got %0d want 0", active_pos); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
        model_pos = 0;
    endtask

    task automatic test_basic();
        int hi, ln; bit st, en;
        enable = 1'b1;
        @(negedge clk);
        model_pos = next_pos(model_pos, int'(position));
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL start_fs got %b want 1", frame_start); end
        checks++; if (pwm_out !== 1'b1) begin errors++; $display("FAIL start_pwm got %b want 1", pwm_out); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b want 1", busy); end
        checks++; if (active_pos !== 6'(model_pos)) begin errors++; $display("FAIL start_pos got %0d want %0d", active_pos, model_pos); end
        measure_frame(-1, 6'd0, -1, -1, hi, ln, st, en);
        checks++; if (!en || ln != PERIOD) begin errors++; $display("FAIL basic_len got %0d want %0d", ln, PERIOD); end
        checks++; if (hi != width_of(model_pos)) begin errors++; $display("FAIL basic_width got %0d want %0d", hi, width_of(model_pos)); end
        // Second frame at position 0; target 63 written during it.
        model_pos = next_pos(model_pos, int'(position));
        measure_frame(0, 6'd63, -1, -1, hi, ln, st, en);
        checks++; if (!en || hi != width_of(model_pos)) begin errors++; $display("FAIL basic_width2 got %0d want %0d", hi, width_of(model_pos)); end
    endtask

    task automatic test_slew();
        int hi, ln; bit st, en;
        for (int f = 0; f < 6; f++) begin
            model_pos = next_pos(model_pos, int'(position));
            checks++; if (active_pos !== 6'(model_pos)) begin errors++; $display("FAIL slew_pos got %0d want %0d", active_pos, model_pos); end
            measure_frame(-1, 6'd0, -1, -1, hi, ln, st, en);
            checks++; if (!en || hi != width_of(model_pos)) begin errors++; $display("FAIL slew_width got %0d want %0d", hi, width_of(model_pos)); end
            if (model_pos == 63) break;
        end
        model_pos = next_pos(model_pos, int'(position));
        measure_frame(5, 6'd60, -1, -1, hi, ln, st, en);
        model_pos = next_pos(model_pos, int'(position));
        checks++; if (active_pos !== 6'(model_pos)) begin errors++; $display("FAIL slew60_pos got %0d want %0d", active_pos, model_pos); end
    endtask

    task automatic test_mid_frame();
        int hi, ln; bit st, en;
        position = 6'd5;
        // Converge on 5 (several frames when slew-limited).
        for (int f = 0; f < 8 && model_pos != 5; f++) begin
            measure_frame(-1, 6'd0, -1, -1, hi, ln, st, en);
            model_pos = next_pos(model_pos, int'(position));
        end
        checks++; if (active_pos !== 6'd5) begin errors++; $display("FAIL mid_pos got %0d want 5", active_pos); end
        measure_frame(3, 6'd40, -1, -1, hi, ln, st, en);
        checks++; if (hi != width_of(5)) begin errors++; $display("FAIL mid_width got %0d want %0d", hi, width_of(5)); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL mid_stable got %b want 1", st); end
        model_pos = next_pos(model_pos, int'(position));
        checks++; if (active_pos !== 6'(model_pos)) begin errors++; $display("FAIL mid_next_pos got %0d want %0d", active_pos, model_pos); end
        measure_frame(-1, 6'd0, -1, -1, hi, ln, st, en);
        checks++; if (hi != width_of(model_pos)) begin errors++; $display("FAIL mid_next_width got %0d want %0d", hi, width_of(model_pos)); end
        model_pos = next_pos(model_pos, int'(position));
    endtask

    task automatic test_random();
        int hi, ln; bit st, en;
        for (int f = 0; f < 8; f++) begin
            checks++; if (active_pos !== 6'(model_pos)) begin errors++; $display("FAIL rnd_pos got %0d want %0d", active_pos, model_pos); end
            measure_frame(int'($urandom_range(PERIOD - 1, 0)), 6'($urandom_range(63, 0)),
                          -1, -1, hi, ln, st, en);
            checks++; if (!en || ln != PERIOD || hi != width_of(model_pos) || !st) begin
                errors++; $display("FAIL rnd_frame got len %0d width %0d want len %0d width %0d",
                                   ln, hi, PERIOD, width_of(model_pos));
            end
            model_pos = next_pos(model_pos, int'(position));
        end
    endtask

    task automatic test_enable_drop();
        int hi, ln; bit st, en;
        measure_frame(-1, 6'd0, 20, -1, hi, ln, st, en);
        checks++; if (!en || ln != PERIOD || hi != width_of(model_pos)) begin
            errors++; $display("FAIL drop_frame got len %0d width %0d want len %0d width %0d",
                               ln, hi, PERIOD, width_of(model_pos));
        end
        checks++; if (busy !== 1'b0 || pwm_out !== 1'b0 || frame_start !== 1'b0) begin
            errors++; $display("FAIL drop_idle got busy %b pwm %b fs %b want 000", busy, pwm_out, frame_start);
        end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_stay got %b want 0", busy); end
        enable = 1'b1;
        @(negedge clk);
        model_pos = next_pos(model_pos, int'(position));
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL reen_fs got %b want 1", frame_start); end
        // Drop then re-assert inside LOW: next frame follows with no gap.
        measure_frame(-1, 6'd0, 20, 50, hi, ln, st, en);
        checks++; if (!en || ln != PERIOD || frame_start !== 1'b1) begin
            errors++; $display("FAIL seamless got len %0d fs %b want len %0d fs 1", ln, frame_start, PERIOD);
        end
        model_pos = next_pos(model_pos, int'(position));
    endtask

    task automatic test_reset_mid();
        int hi, ln; bit st, en;
        position = 6'd20;
        repeat (3) @(negedge clk);
        checks++; if (pwm_out !== 1'b1) begin errors++; $display("FAIL pre_reset_pwm got %b want 1", pwm_out); end
        reset_n = 1'b0;
        #1;
        checks++; if (pwm_out !== 1'b0 || busy !== 1'b0 || frame_start !== 1'b0 || active_pos !== 6'd0) begin
            errors++; $display("FAIL async_reset got pwm %b busy %b fs %b pos %0d want 0 0 0 0",
                               pwm_out, busy, frame_start, active_pos);
        end
        model_pos = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        model_pos = next_pos(model_pos, int'(position));
        checks++; if (frame_start !== 1'b1 || active_pos !== 6'(model_pos)) begin
            errors++; $display("FAIL post_reset got fs %b pos %0d want fs 1 pos %0d", frame_start, active_pos, model_pos);
        end
        measure_frame(-1, 6'd0, -1, -1, hi, ln, st, en);
        checks++; if (!en || ln != PERIOD || hi != width_of(model_pos)) begin
            errors++; $display("FAIL post_reset_frame got len %0d width %0d want len %0d width %0d",
                               ln, hi, PERIOD, width_of(model_pos));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slew();
        test_mid_frame();
        test_random();
        test_enable_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
